// File: rtl/seq_code_counter.sv
// Parametrised modulo-N up/down sequence counter with load, enable, carry/borrow and binary/Gray output.
// Optional wrap-sticky flag enabled by defining SEQ_CODE_COUNTER_STICKY_EN.
module seq_code_counter #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned MODULUS   = 6,
    parameter int unsigned GRAY      = 1,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef SEQ_CODE_COUNTER_STICKY_EN
    input  logic             clr_sticky,
    output logic             sticky,
`endif
    output logic [WIDTH-1:0] idx,
    output logic [WIDTH-1:0] Q,
    output logic             C
);

    localparam int unsigned IW = WIDTH + 1;
    localparam logic [WIDTH:0] MOD_W  = IW'(MODULUS);
    localparam logic [WIDTH:0] LAST_W = IW'(MODULUS - 1);
    localparam logic [WIDTH:0] OFF_W  = IW'(((32'd1 << WIDTH) - MODULUS) / 2);
    localparam logic           RST_C  = (RESET_VAL == MODULUS - 1);

    // Reject illegal parameter combinations at elaboration
    if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (32'd1 << WIDTH) ||
        (GRAY != 0 && (MODULUS % 2) != 0) || RESET_VAL >= MODULUS) begin : g_bad_param
        initial begin
            $display("seq_code_counter: illegal parameters WIDTH=%0d MODULUS=%0d GRAY=%0d RESET_VAL=%0d",
                     WIDTH, MODULUS, GRAY, RESET_VAL);
            $finish;
        end
    end

    // Reflected-excess Gray: offset centres the used codes so the wrap is also one bit
    function automatic logic [WIDTH-1:0] enc(input logic [WIDTH:0] i);
        logic [WIDTH:0] g;
        g = (GRAY != 0) ? i + OFF_W : i;
        return (GRAY != 0) ? WIDTH'(g ^ (g >> 1)) : WIDTH'(g);
    endfunction

    logic [WIDTH:0] idx_w;
    logic [WIDTH:0] idx_nxt_c;
    logic           upd_c;
    logic           wrap_c;
    logic           c_nxt_c;

    assign idx_w = {1'b0, idx};

    // Next index: load beats count; arithmetic carried in WIDTH+1 bits
    always_comb begin
        idx_nxt_c = idx_w;
        upd_c     = 1'b0;
        wrap_c    = 1'b0;
        if (load) begin
            upd_c     = 1'b1;
            idx_nxt_c = ({1'b0, load_val} >= MOD_W) ? '0 : {1'b0, load_val};
        end else if (en) begin
            upd_c = 1'b1;
            if (!dir) begin
                if (idx_w == LAST_W) begin
                    idx_nxt_c = '0;
                    wrap_c    = 1'b1;
                end else begin
                    idx_nxt_c = idx_w + IW'(1);
                end
            end else begin
                if (idx_w == '0) begin
                    idx_nxt_c = LAST_W;
                    wrap_c    = 1'b1;
                end else begin
                    idx_nxt_c = idx_w - IW'(1);
                end
            end
        end
        c_nxt_c = dir ? (idx_nxt_c == '0) : (idx_nxt_c == LAST_W);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= WIDTH'(RESET_VAL);
            Q   <= enc(IW'(RESET_VAL));
            C   <= RST_C;
        end else if (upd_c) begin
            idx <= idx_nxt_c[WIDTH-1:0];
            Q   <= enc(idx_nxt_c);
            C   <= c_nxt_c;
        end
    end

`ifdef SEQ_CODE_COUNTER_STICKY_EN
    // Wrap has priority over clear so a wrap is never lost
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky <= 1'b0;
        end else if (!load && wrap_c) begin
            sticky <= 1'b1;
        end else if (clr_sticky) begin
            sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_seq_code_counter.sv
// Scoreboard bench for seq_code_counter: three parameterisations driven in lockstep against a modulo-arithmetic model.
module tb_seq_code_counter;

    localparam int NDUT = 3;
    localparam int W [NDUT]  = '{3, 4, 4};
    localparam int M [NDUT]  = '{6, 10, 16};
    localparam int G [NDUT]  = '{1, 1, 0};
    localparam int RV [NDUT] = '{0, 9, 0};

    typedef struct packed {
        logic [NDUT-1:0][15:0] idx;
        logic [NDUT-1:0][15:0] q;
        logic [NDUT-1:0]       c;
        logic [NDUT-1:0]       st;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [3:0] lv4 = 4'd0;
`ifdef SEQ_CODE_COUNTER_STICKY_EN
    logic       clr_sticky = 1'b0;
    logic       st_a, st_b, st_c;
`endif
    logic [2:0] idx_a, q_a;
    logic [3:0] idx_b, q_b, idx_c, q_c;
    logic       c_a, c_b, c_c;

    int vectors = 0;
    int miscompares = 0;
    exp_t sbq[$];
    int m_idx [NDUT];
    int m_c [NDUT];
    int m_st [NDUT];

    always #5 clk = ~clk;

    seq_code_counter #(.WIDTH(3), .MODULUS(6), .GRAY(1), .RESET_VAL(0)) dut_a (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(lv4[2:0]),
`ifdef SEQ_CODE_COUNTER_STICKY_EN
        .clr_sticky(clr_sticky), .sticky(st_a),
`endif
        .idx(idx_a), .Q(q_a), .C(c_a));

    seq_code_counter #(.WIDTH(4), .MODULUS(10), .GRAY(1), .RESET_VAL(9)) dut_b (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(lv4),
`ifdef SEQ_CODE_COUNTER_STICKY_EN
        .clr_sticky(clr_sticky), .sticky(st_b),
`endif
        .idx(idx_b), .Q(q_b), .C(c_b));

    seq_code_counter #(.WIDTH(4), .MODULUS(16), .GRAY(0), .RESET_VAL(0)) dut_c (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(lv4),
`ifdef SEQ_CODE_COUNTER_STICKY_EN
        .clr_sticky(clr_sticky), .sticky(st_c),
`endif
        .idx(idx_c), .Q(q_c), .C(c_c));

    function automatic int enc(input int k, input int i);
        int g;
        if (G[k] == 0) return i;
        g = i + ((1 << W[k]) - M[k]) / 2;
        return g ^ (g >> 1);
    endfunction

    // One stimulus cycle: drive inputs, advance the reference model, queue the expected outputs
    task automatic cyc(input bit r, input bit ld, input int lv, input bit e, input bit d, input bit cl);
        exp_t x;
        @(negedge clk);
        reset = r; load = ld; lv4 = 4'(lv); en = e; dir = d;
`ifdef SEQ_CODE_COUNTER_STICKY_EN
        clr_sticky = cl;
`endif
        for (int k = 0; k < NDUT; k++) begin
            int m, v, nxt;
            bit wrap;
            m = M[k];
            v = lv % (1 << W[k]);
            wrap = 1'b0;
            nxt = m_idx[k];
            if (r) begin
                nxt = RV[k];
                m_c[k] = (RV[k] == m - 1) ? 1 : 0;
                m_st[k] = 0;
            end else begin
                if (ld) begin
                    nxt = (v >= m) ? 0 : v;
                end else if (e) begin
                    nxt = d ? (m_idx[k] + m - 1) % m : (m_idx[k] + 1) % m;
                    wrap = d ? (m_idx[k] == 0) : (m_idx[k] == m - 1);
                end
                if (ld || e) m_c[k] = (d ? (nxt == 0) : (nxt == m - 1)) ? 1 : 0;
                if (wrap) m_st[k] = 1;
                else if (cl) m_st[k] = 0;
            end
            m_idx[k] = nxt;
            x.idx[k] = 16'(nxt);
            x.q[k]   = 16'(enc(k, nxt));
            x.c[k]   = m_c[k][0];
            x.st[k]  = m_st[k][0];
        end
        sbq.push_back(x);
    endtask

    task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[dut%0d] at %0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle, so pop one expectation per edge
    initial begin
        exp_t x;
        logic [15:0] ai [NDUT];
        logic [15:0] aq [NDUT];
        logic        ac [NDUT];
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                ai[0] = 16'(idx_a); ai[1] = 16'(idx_b); ai[2] = 16'(idx_c);
                aq[0] = 16'(q_a);   aq[1] = 16'(q_b);   aq[2] = 16'(q_c);
                ac[0] = c_a;        ac[1] = c_b;        ac[2] = c_c;
                for (int k = 0; k < NDUT; k++) begin
                    chk("idx", k, ai[k], x.idx[k]);
                    chk("Q", k, aq[k], x.q[k]);
                    chk("C", k, 16'(ac[k]), 16'(x.c[k]));
                end
`ifdef SEQ_CODE_COUNTER_STICKY_EN
                chk("sticky", 0, 16'(st_a), 16'(x.st[0]));
                chk("sticky", 1, 16'(st_b), 16'(x.st[1]));
                chk("sticky", 2, 16'(st_c), 16'(x.st[2]));
`endif
            end
        end
    end

    initial begin
        bit d;
        for (int k = 0; k < NDUT; k++) begin
            m_idx[k] = 0; m_c[k] = 0; m_st[k] = 0;
        end
        // Reset then count up through a wrap
        cyc(1, 0, 0, 0, 0, 0);
        repeat (7) cyc(0, 0, 0, 1, 0, 0);
        // Load 3 then count down through the 0 -> MODULUS-1 borrow
        cyc(0, 1, 3, 0, 1, 0);
        repeat (5) cyc(0, 0, 0, 1, 1, 0);
        // Load wins over en; out-of-range load clamps; hold with dir toggling
        cyc(0, 1, 7, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        // Reset mid-count, then resume
        cyc(0, 1, 4, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 1, 0, 0);
        // Full-period count covering every wrap
        cyc(1, 0, 0, 0, 0, 0);
        repeat (17) cyc(0, 0, 0, 1, 0, 0);
        // Sticky: clear coinciding with wrap, hold, then clear alone
        cyc(0, 1, 5, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1);
        repeat (2) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 1, 15, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1);
        // Randomised traffic with direction runs
        d = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) d = ~d;
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), d,
                ($urandom_range(0, 7) == 0));
        end
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
